// File: rtl/fpu_register_sb_if.sv
// Operand-read, forwarding, writeback and long-latency issue bundle for fpu_register_sb.
// master = decode/execute side, slave = the register file.
interface fpu_register_sb_if #(
  parameter int FLEN       = 32,
  parameter int NUM_REGS   = 32,
  parameter int FWD_STAGES = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic [2:0]               rd_en;
  logic [3*AW-1:0]          rd_addr;
  logic [3*FLEN-1:0]        rd_data;

  logic [FWD_STAGES-1:0]    fwd_valid;
  logic [FWD_STAGES*AW-1:0] fwd_addr;
  logic [FWD_STAGES*FLEN-1:0] fwd_data;

  logic                     wb_valid;
  logic [AW-1:0]            wb_addr;
  logic [FLEN-1:0]          wb_data;

  logic                     lw_valid;
  logic [AW-1:0]            lw_addr;
  logic [FLEN-1:0]          lw_data;

  logic                     iss_valid;
  logic                     iss_long;
  logic [AW-1:0]            iss_waddr;
  logic                     flush;

  logic                     stall;
  logic [AW:0]              pend_cnt;

  modport master (
    output rd_en, rd_addr, fwd_valid, fwd_addr, fwd_data,
           wb_valid, wb_addr, wb_data, lw_valid, lw_addr, lw_data,
           iss_valid, iss_long, iss_waddr, flush,
    input  rd_data, stall, pend_cnt
  );

  modport slave (
    input  rd_en, rd_addr, fwd_valid, fwd_addr, fwd_data,
           wb_valid, wb_addr, wb_data, lw_valid, lw_addr, lw_data,
           iss_valid, iss_long, iss_waddr, flush,
    output rd_data, stall, pend_cnt
  );
endinterface

// File: rtl/fpu_register_sb.sv
// FP register file with three-source forwarding read and a long-latency pending scoreboard.
// Optional feature macro: FPU_SCOREBOARD_EN (scoreboard, stall and pend_cnt; tied off when undefined).
module fpu_register_sb #(
  parameter int FLEN       = 32,
  parameter int NUM_REGS   = 32,
  parameter int FWD_STAGES = 2
) (
  input  logic               clock,
  input  logic               reset,
  fpu_register_sb_if.slave   bus
);
  localparam int AW = $clog2(NUM_REGS);

  logic [FLEN-1:0]   regs_q [NUM_REGS];
  logic [3*FLEN-1:0] rd_data_c;

  // wb is applied after lw so that a same-address collision keeps wb_data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      if (bus.lw_valid) regs_q[bus.lw_addr] <= bus.lw_data;
      if (bus.wb_valid) regs_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_comb begin
    logic          hit;
    logic [AW-1:0] addr;
    rd_data_c = '0;
    hit       = 1'b0;
    addr      = '0;
    for (int i = 0; i < 3; i++) begin
      hit  = 1'b0;
      addr = bus.rd_addr[i*AW +: AW];
      if (bus.rd_en[i]) begin
        for (int j = 0; j < FWD_STAGES; j++) begin
          if (!hit && bus.fwd_valid[j] && (bus.fwd_addr[j*AW +: AW] == addr)) begin
            rd_data_c[i*FLEN +: FLEN] = bus.fwd_data[j*FLEN +: FLEN];
            hit = 1'b1;
          end
        end
        if (!hit && bus.wb_valid && (bus.wb_addr == addr)) begin
          rd_data_c[i*FLEN +: FLEN] = bus.wb_data;
          hit = 1'b1;
        end
        if (!hit && bus.lw_valid && (bus.lw_addr == addr)) begin
          rd_data_c[i*FLEN +: FLEN] = bus.lw_data;
          hit = 1'b1;
        end
        if (!hit) begin
          rd_data_c[i*FLEN +: FLEN] = regs_q[addr];
        end
      end
    end
  end

  assign bus.rd_data = rd_data_c;

`ifdef FPU_SCOREBOARD_EN
  logic [NUM_REGS-1:0] pending_q;
  logic [AW:0]         pend_cnt_q;
  logic                src_hz;
  logic                waw_hz;
  logic                stall_c;
  logic                set_c;
  logic                inc_c;
  logic                dec_c;

  // a pending register whose result lands on lw this cycle is bypassed, not stalled
  always_comb begin
    logic [AW-1:0] addr;
    src_hz = 1'b0;
    addr   = '0;
    for (int i = 0; i < 3; i++) begin
      addr = bus.rd_addr[i*AW +: AW];
      if (bus.rd_en[i] && pending_q[addr] && !(bus.lw_valid && (bus.lw_addr == addr))) begin
        src_hz = 1'b1;
      end
    end
    waw_hz  = bus.iss_valid && pending_q[bus.iss_waddr]
              && !(bus.lw_valid && (bus.lw_addr == bus.iss_waddr));
    stall_c = !bus.flush && (src_hz || waw_hz);
    set_c   = bus.iss_valid && bus.iss_long && !stall_c && !bus.flush;
    inc_c   = set_c && !pending_q[bus.iss_waddr];
    dec_c   = bus.lw_valid && pending_q[bus.lw_addr]
              && !(set_c && (bus.iss_waddr == bus.lw_addr));
  end

  // set is written after clear so it wins on a same-register collision
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q  <= '0;
      pend_cnt_q <= '0;
    end else if (bus.flush) begin
      pending_q  <= '0;
      pend_cnt_q <= '0;
    end else begin
      if (bus.lw_valid) pending_q[bus.lw_addr]   <= 1'b0;
      if (set_c)        pending_q[bus.iss_waddr] <= 1'b1;
      pend_cnt_q <= pend_cnt_q + {{AW{1'b0}}, inc_c} - {{AW{1'b0}}, dec_c};
    end
  end

  assign bus.stall    = stall_c;
  assign bus.pend_cnt = pend_cnt_q;
`else
  logic unused_scoreboard;
  assign unused_scoreboard = ^{bus.iss_valid, bus.iss_long, bus.iss_waddr, bus.flush};
  assign bus.stall         = 1'b0;
  assign bus.pend_cnt      = '0;
`endif

endmodule

// File: tb/tb_fpu_register_sb.sv
// Directed bench for fpu_register_sb: expectations queued per step, popped and checked after settling.
module tb_fpu_register_sb;
  localparam int FLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int FWD_STAGES = 2;
  localparam int AW         = $clog2(NUM_REGS);
`ifdef FPU_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  localparam int SEL_STALL = 3;
  localparam int SEL_PEND  = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fpu_register_sb_if #(.FLEN(FLEN), .NUM_REGS(NUM_REGS), .FWD_STAGES(FWD_STAGES)) bus ();

  fpu_register_sb #(.FLEN(FLEN), .NUM_REGS(NUM_REGS), .FWD_STAGES(FWD_STAGES)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic idle();
    bus.rd_en     = '0;
    bus.rd_addr   = '0;
    bus.fwd_valid = '0;
    bus.fwd_addr  = '0;
    bus.fwd_data  = '0;
    bus.wb_valid  = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.lw_valid  = 1'b0;
    bus.lw_addr   = '0;
    bus.lw_data   = '0;
    bus.iss_valid = 1'b0;
    bus.iss_long  = 1'b0;
    bus.iss_waddr = '0;
    bus.flush     = 1'b0;
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    bus.rd_en[i]            = 1'b1;
    bus.rd_addr[i*AW +: AW] = a;
  endtask

  task automatic set_fwd(input int j, input logic [AW-1:0] a, input logic [FLEN-1:0] d);
    bus.fwd_valid[j]            = 1'b1;
    bus.fwd_addr[j*AW +: AW]    = a;
    bus.fwd_data[j*FLEN +: FLEN] = d;
  endtask

  task automatic set_wb(input logic [AW-1:0] a, input logic [FLEN-1:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = a;
    bus.wb_data  = d;
  endtask

  task automatic set_lw(input logic [AW-1:0] a, input logic [FLEN-1:0] d);
    bus.lw_valid = 1'b1;
    bus.lw_addr  = a;
    bus.lw_data  = d;
  endtask

  task automatic issue_long(input logic [AW-1:0] a);
    bus.iss_valid = 1'b1;
    bus.iss_long  = 1'b1;
    bus.iss_waddr = a;
  endtask

  task automatic expect_val(input string tag, input int sel, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      0, 1, 2:   observe = 64'(bus.rd_data[sel*FLEN +: FLEN]);
      SEL_STALL: observe = 64'(bus.stall);
      default:   observe = 64'(bus.pend_cnt);
    endcase
  endfunction

  task automatic check_all();
    exp_t        e;
    logic [63:0] o;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = observe(e.sel);
      tests++;
      assert (o === e.exp) else begin
        failed++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
      end
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;

    // reset state
    @(negedge clock);
    set_rd(0, 5'd0); set_rd(1, 5'd1); set_rd(2, 5'd2);
    expect_val("reset_rd0", 0, 64'h0);
    expect_val("reset_rd1", 1, 64'h0);
    expect_val("reset_rd2", 2, 64'h0);
    expect_val("reset_stall", SEL_STALL, 64'h0);
    expect_val("reset_pend", SEL_PEND, 64'h0);
    check_all();
    reset = 1'b0;

    // write f5, park a long op on f20, then reset mid-cycle
    @(negedge clock); idle();
    set_wb(5'd5, 32'h3F80_0000);
    issue_long(5'd20);
    expect_val("wr_f5_stall", SEL_STALL, 64'h0);
    check_all();
    @(negedge clock); idle();
    set_rd(0, 5'd5);
    expect_val("f5_before_reset", 0, 64'h3F80_0000);
    expect_val("pend_before_reset", SEL_PEND, SB ? 64'd1 : 64'd0);
    check_all();
    reset = 1'b1;
    expect_val("f5_after_reset", 0, 64'h0);
    expect_val("rd1_disabled", 1, 64'h0);
    expect_val("pend_after_reset", SEL_PEND, 64'h0);
    expect_val("stall_after_reset", SEL_STALL, 64'h0);
    check_all();
    @(negedge clock);
    reset = 1'b0;

    // forwarding priority and lw bypass
    idle();
    set_fwd(0, 5'd3, 32'h4000_0000);
    set_fwd(1, 5'd3, 32'h4040_0000);
    set_wb(5'd3, 32'h4080_0000);
    set_lw(5'd6, 32'h1111_1111);
    set_rd(0, 5'd3); set_rd(2, 5'd6);
    expect_val("fwd0_wins", 0, 64'h4000_0000);
    expect_val("lw_bypass", 2, 64'h1111_1111);
    check_all();
    @(negedge clock); idle();
    set_rd(0, 5'd3); set_rd(2, 5'd6);
    expect_val("array_f3_wb", 0, 64'h4080_0000);
    expect_val("array_f6_lw", 2, 64'h1111_1111);
    check_all();

    // fwd[1] only match; wb beats lw on a shared address
    set_fwd(0, 5'd1, 32'hAAAA_0000);
    set_fwd(1, 5'd3, 32'h4040_0000);
    set_wb(5'd8, 32'hA5A5_A5A5);
    set_lw(5'd8, 32'h5A5A_5A5A);
    set_rd(1, 5'd3); set_rd(0, 5'd8);
    expect_val("fwd1_match", 1, 64'h4040_0000);
    expect_val("wb_over_lw_bypass", 0, 64'hA5A5_A5A5);
    check_all();
    @(negedge clock); idle();
    set_rd(0, 5'd8);
    expect_val("wb_over_lw_array", 0, 64'hA5A5_A5A5);
    check_all();

    // long-op RAW hazard resolved by lw bypass
    @(negedge clock); idle();
    issue_long(5'd7);
    expect_val("iss_f7_stall", SEL_STALL, 64'h0);
    check_all();
    @(negedge clock); idle();
    set_rd(1, 5'd7);
    expect_val("raw_f7_stall", SEL_STALL, SB ? 64'd1 : 64'd0);
    expect_val("raw_f7_pend", SEL_PEND, SB ? 64'd1 : 64'd0);
    check_all();
    set_lw(5'd7, 32'h4120_0000);
    expect_val("raw_f7_lw_stall", SEL_STALL, 64'h0);
    expect_val("raw_f7_lw_data", 1, 64'h4120_0000);
    check_all();
    @(negedge clock); idle();
    set_rd(1, 5'd7);
    expect_val("f7_cleared_pend", SEL_PEND, 64'h0);
    expect_val("f7_cleared_stall", SEL_STALL, 64'h0);
    expect_val("f7_array", 1, 64'h4120_0000);
    check_all();

    // WAW with simultaneous lw to the same register
    @(negedge clock); idle();
    issue_long(5'd9);
    expect_val("iss_f9_stall", SEL_STALL, 64'h0);
    check_all();
    @(negedge clock); idle();
    issue_long(5'd9);
    set_lw(5'd9, 32'h4110_0000);
    expect_val("waw_lw_stall", SEL_STALL, 64'h0);
    expect_val("waw_lw_pend_before", SEL_PEND, SB ? 64'd1 : 64'd0);
    check_all();
    @(negedge clock); idle();
    issue_long(5'd9);
    set_rd(0, 5'd9);
    expect_val("waw_pend_kept", SEL_PEND, SB ? 64'd1 : 64'd0);
    expect_val("waw_stall", SEL_STALL, SB ? 64'd1 : 64'd0);
    expect_val("f9_array", 0, 64'h4110_0000);
    check_all();
    @(negedge clock); idle();
    set_lw(5'd9, 32'h4130_0000);
    check_all();
    @(negedge clock); idle();
    expect_val("f9_cleared_pend", SEL_PEND, 64'h0);
    check_all();

    // back-to-back long issues then flush with a colliding issue
    for (int k = 10; k < 13; k++) begin
      @(negedge clock); idle();
      issue_long(AW'(k));
      expect_val("b2b_iss_stall", SEL_STALL, 64'h0);
      check_all();
    end
    @(negedge clock); idle();
    set_rd(0, 5'd10);
    expect_val("three_pend", SEL_PEND, SB ? 64'd3 : 64'd0);
    expect_val("pend_read_stall", SEL_STALL, SB ? 64'd1 : 64'd0);
    check_all();
    bus.flush = 1'b1;
    issue_long(5'd2);
    expect_val("flush_stall_forced", SEL_STALL, 64'h0);
    check_all();
    @(negedge clock); idle();
    set_rd(0, 5'd2); set_rd(1, 5'd10);
    expect_val("post_flush_pend", SEL_PEND, 64'h0);
    expect_val("post_flush_stall", SEL_STALL, 64'h0);
    check_all();

    // lw to a register that is not pending
    set_lw(5'd13, 32'hDEAD_BEEF);
    set_rd(2, 5'd13);
    expect_val("lw_nonpend_bypass", 2, 64'hDEAD_BEEF);
    check_all();
    @(negedge clock); idle();
    set_rd(2, 5'd13);
    expect_val("lw_nonpend_array", 2, 64'hDEAD_BEEF);
    expect_val("lw_nonpend_pend", SEL_PEND, 64'h0);
    check_all();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/fpu_register_sb.md
# fpu_register_sb

Parametrised floating-point register file with multi-source forwarding and a long-latency scoreboard, the next-generation replacement for the current FP register file and forwarding pair. It sits between decode/register-read and the FP execute stage, returns operand data for up to three sources, and raises a stall when an operand or destination belongs to an in-flight divide/sqrt result. Results arrive on an in-order writeback port and a separate out-of-order long-latency writeback port.

## Interface
- FLEN, 32: data width of each FP register; legal values are 32 and 64.
- NUM_REGS, 32: number of registers. AW = $clog2(NUM_REGS).
- FWD_STAGES, 2: number of execute/memory forwarding sources; index 0 is the youngest.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- rd_en  in  3  read enable per source (rs1, rs2, rs3)
- rd_addr  in  3*AW  read addresses, source i at [i*AW +: AW]
- rd_data  out  3*FLEN  read data, source i at [i*FLEN +: FLEN]
- fwd_valid  in  FWD_STAGES  forwarding source valid
- fwd_addr  in  FWD_STAGES*AW  forwarding destination
- fwd_data  in  FWD_STAGES*FLEN  forwarding data
- wb_valid, wb_addr, wb_data  in  1, AW, FLEN  in-order writeback port
- lw_valid, lw_addr, lw_data  in  1, AW, FLEN  long-latency writeback port; clears pending
- iss_valid  in  1  an FP instruction issues this cycle
- iss_long  in  1  the issuing instruction is long-latency (fdiv/fsqrt)
- iss_waddr  in  AW  destination of the issuing instruction
- flush  in  1  squash all in-flight long-latency operations
- stall  out  1  hazard; issue must be held
- pend_cnt  out  AW+1  registered count of pending registers

## Operation
- Array: NUM_REGS x FLEN flops, all cleared to 0 by reset. No hardwired-zero register.
- Writes on the clock edge: wb writes when wb_valid; lw writes when lw_valid. If both target the same address in one cycle, wb_data is stored.
- Read data per source i, first match wins:
  - rd_en[i]=0: 0.
  - fwd[0] … fwd[FWD_STAGES-1], where valid and address matches.
  - wb port, on valid and address match.
  - lw port, on valid and address match.
  - array[rd_addr[i]].
- Scoreboard: one pending bit per register.
  - Set: iss_valid & iss_long & ~stall & ~flush sets pending[iss_waddr].
  - Clear: lw_valid clears pending[lw_addr].
  - Set and clear of the same register in one cycle: set wins.
  - flush clears every bit and suppresses the set in that cycle.
- stall is asserted when either holds:
  - Any enabled source reads a pending register whose lw_addr does not match in this cycle (an lw match is bypassed, not a stall).
  - iss_valid and pending[iss_waddr], unless lw clears that register this cycle (WAW).
- stall is forced to 0 during flush.
- pend_cnt equals the population count of the pending bits after each edge. It is maintained incrementally (+1 on set of a clear bit, -1 on clear of a set bit) and reloaded to 0 on flush.
- lw_valid to a non-pending register is legal: the data is written and the count is unchanged.

## Timing
- Reset values: all registers 0, all pending bits 0, pend_cnt 0, stall 0, rd_data 0.
- Reset is asynchronous on assert and takes effect mid-operation without waiting for an edge. Deassertion is synchronous to the clock by system convention.
- rd_data and stall are combinational from the current-cycle inputs and state. Read-after-write within a cycle returns the new data through the bypass path.
- A pending bit set at edge N is visible to stall in cycle N+1.
- Back-to-back long issues to different destinations are allowed every cycle. pend_cnt saturates only structurally, since it cannot exceed NUM_REGS.

## Configuration
- FPU_SCOREBOARD_EN defined: the scoreboard, stall and pend_cnt behave as described above.
- FPU_SCOREBOARD_EN undefined:
  - Pending bits and counter are not built.
  - stall is tied to 0 and pend_cnt to 0.
  - iss_* and flush are ignored.
  - The lw port remains a plain second write/bypass port.

## Test plan
- Reset then read: assert reset mid-run after writing 0x3F800000 to f5. Reading f5 with rd_en=3'b001 returns 0, pend_cnt=0, stall=0.
- Forward priority: fwd[0]=(f3,0x40000000), fwd[1]=(f3,0x40400000), wb=(f3,0x40800000) all in one cycle. rs1=f3 returns 0x40000000, and the array holds 0x40800000 next cycle.
- Long-op hazard: issue long to f7.
  - Next cycle, rs2=f7 gives stall=1 and pend_cnt=1.
  - lw=(f7,0x41200000) in the same cycle gives stall=0 and rs2=0x41200000; the following cycle pend_cnt=0.
- WAW with simultaneous events: f9 pending; iss long to f9 together with lw to f9 gives stall=0, f9 stays pending, and pend_cnt stays 1.
- Flush: three long ops pending (pend_cnt=3), then flush together with iss long to f2. Next cycle pend_cnt=0, stall=0, and reading f2 does not stall.
- Macro off: build without FPU_SCOREBOARD_EN; issue long to f4, then read f4 gives stall=0 and pend_cnt=0.
